// File: rtl/arb_pkg.sv
// Shared constants, FSM state encoding and rotating-priority search for the
// four-way round-robin arbiter.
package arb_pkg;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned IDX_W   = 2;

    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE = 1'b0;
    localparam state_t ST_BUSY = 1'b1;

    // First set bit of req searching ptr+1, ptr+2, ptr+3, ptr (mod NUM_REQ).
    // Caller guarantees req is non-zero.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                                 input logic [IDX_W-1:0]   ptr);
        logic [IDX_W-1:0] idx;
        rr_pick = ptr;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = ptr + IDX_W'(k);
            if (req[idx]) begin
                rr_pick = idx;
            end
        end
    endfunction

endpackage

// File: rtl/onehot_enc4.sv
// One-hot to binary encoder for the 4-bit grant vector; zero input gives 0.
module onehot_enc4
    import arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] onehot,
    output logic [IDX_W-1:0]   idx_c
);

    always_comb begin
        idx_c = {onehot[3] | onehot[2], onehot[3] | onehot[1]};
    end

endmodule

// File: rtl/rr_arbiter4.sv
// Four-requester round-robin arbiter with hold-until-release grants.
// Define RR_TIMEOUT_EN to enable forced release after HOLD_MAX owner cycles.
module rr_arbiter4
    import arb_pkg::*;
#(
    parameter int unsigned HOLD_MAX = 15
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               En,
    input  logic [NUM_REQ-1:0] Req,
    input  logic               Done,
    output logic [NUM_REQ-1:0] Gnt,
    output logic [IDX_W-1:0]   GntIdx,
    output logic               Valid,
    output logic               Timeout
);

    if (HOLD_MAX == 0 || HOLD_MAX > 255) begin : g_hold_max_bad
        $error("rr_arbiter4: HOLD_MAX must be in 1..255");
    end

    state_t             state;
    state_t             state_nx;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   ptr_nx;
    logic [NUM_REQ-1:0] gnt_nx;
    logic [IDX_W-1:0]   idx_nx_c;
    logic               timeout_nx;
    logic [NUM_REQ-1:0] cand;
    logic               drop;
    logic               forced;

    // Owner index is always ptr while BUSY, so the forced-release check keys off it.
`ifdef RR_TIMEOUT_EN
    logic [7:0] hold_cnt;
    logic [7:0] hold_cnt_nx;

    assign forced = (state == ST_BUSY) && (hold_cnt == 8'(HOLD_MAX - 1))
                    && !Done && Req[ptr];

    always_comb begin
        hold_cnt_nx = 8'd0;
        if (state == ST_BUSY && !drop) begin
            hold_cnt_nx = hold_cnt + 8'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            hold_cnt <= 8'd0;
        end else begin
            hold_cnt <= hold_cnt_nx;
        end
    end
`else
    assign forced = 1'b0;
`endif

    always_comb begin
        state_nx   = state;
        ptr_nx     = ptr;
        gnt_nx     = Gnt;
        timeout_nx = 1'b0;
        cand       = '0;
        drop       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (En && (|Req)) begin
                    ptr_nx   = rr_pick(Req, ptr);
                    gnt_nx   = NUM_REQ'(1) << ptr_nx;
                    state_nx = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // A dropped owner request counts as Done; the owner is masked
                // out so it cannot win again on its own release edge.
                drop = Done || !Req[ptr] || forced;
                if (drop) begin
                    timeout_nx = forced;
                    cand       = Req & ~Gnt;
                    if (En && (|cand)) begin
                        ptr_nx = rr_pick(cand, ptr);
                        gnt_nx = NUM_REQ'(1) << ptr_nx;
                    end else begin
                        gnt_nx   = '0;
                        state_nx = ST_IDLE;
                    end
                end
            end
            default: begin
                gnt_nx   = '0;
                state_nx = ST_IDLE;
            end
        endcase
    end

    onehot_enc4 u_enc (
        .onehot (gnt_nx),
        .idx_c  (idx_nx_c)
    );

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state   <= ST_IDLE;
            ptr     <= IDX_W'(NUM_REQ - 1);
            Gnt     <= '0;
            GntIdx  <= '0;
            Valid   <= 1'b0;
            Timeout <= 1'b0;
        end else begin
            state   <= state_nx;
            ptr     <= ptr_nx;
            Gnt     <= gnt_nx;
            GntIdx  <= idx_nx_c;
            Valid   <= |gnt_nx;
            Timeout <= timeout_nx;
        end
    end

endmodule

// File: tb/tb_rr_arbiter4.sv
// Scoreboard bench for rr_arbiter4: directed vectors push expected outputs,
// a negedge monitor pops and compares them on the cycle they are due.
module tb_rr_arbiter4;

    logic       Clk;
    logic       Rst;
    logic       En;
    logic [3:0] Req;
    logic       Done;
    logic [3:0] Gnt;
    logic [1:0] GntIdx;
    logic       Valid;
    logic       Timeout;

    typedef struct {
        int unsigned cyc;
        int unsigned id;
        logic [3:0]  gnt;
        logic [1:0]  idx;
        logic        vld;
        logic        tmo;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned cyc;
    int unsigned n_vec;
    int unsigned n_cmp;
    int unsigned n_bad;
    bit          stim_done;

    rr_arbiter4 #(.HOLD_MAX(4)) dut (
        .Clk     (Clk),
        .Rst     (Rst),
        .En      (En),
        .Req     (Req),
        .Done    (Done),
        .Gnt     (Gnt),
        .GntIdx  (GntIdx),
        .Valid   (Valid),
        .Timeout (Timeout)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    always @(posedge Clk) cyc <= cyc + 1;

    // Apply one input vector after the edge; expected outputs are due one edge later.
    task automatic vec(input logic rst, input logic en, input logic [3:0] req,
                       input logic done, input logic [3:0] gnt, input logic tmo);
        exp_t e;
        @(posedge Clk);
        #1;
        Rst  = rst;
        En   = en;
        Req  = req;
        Done = done;
        n_vec++;
        e.cyc = cyc + 1;
        e.id  = n_vec;
        e.gnt = gnt;
        e.vld = (gnt != 4'b0000);
        e.idx = 2'b00;
        for (int i = 0; i < 4; i++) begin
            if (gnt[i]) e.idx = 2'(i);
        end
        e.tmo = tmo;
        exp_q.push_back(e);
    endtask

    always @(negedge Clk) begin
        exp_t e;
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (e.cyc != cyc) begin
                n_bad++;
                $display("FAIL vec%0d late: due cycle %0d, checked cycle %0d", e.id, e.cyc, cyc);
            end else if (Gnt !== e.gnt || GntIdx !== e.idx || Valid !== e.vld || Timeout !== e.tmo) begin
                n_bad++;
                $display("FAIL vec%0d: got Gnt=%b GntIdx=%b Valid=%b Timeout=%b, expected Gnt=%b GntIdx=%b Valid=%b Timeout=%b",
                         e.id, Gnt, GntIdx, Valid, Timeout, e.gnt, e.idx, e.vld, e.tmo);
            end
        end
    end

    initial begin
        cyc       = 0;
        n_vec     = 0;
        n_cmp     = 0;
        n_bad     = 0;
        stim_done = 1'b0;
        Rst       = 1'b1;
        En        = 1'b0;
        Req       = 4'b0000;
        Done      = 1'b0;

        // reset state
        vec(1, 0, 4'b0000, 0, 4'b0000, 0);
        vec(1, 1, 4'b1111, 1, 4'b0000, 0);
        // first grant from Ptr=3 with Req=1010
        vec(0, 1, 4'b1010, 0, 4'b0010, 0);
        vec(0, 1, 4'b1010, 1, 4'b1000, 0);
        vec(0, 1, 4'b0000, 1, 4'b0000, 0);
        // full rotation with back-to-back Done
        vec(0, 1, 4'b1111, 0, 4'b0001, 0);
        vec(0, 1, 4'b1111, 1, 4'b0010, 0);
        vec(0, 1, 4'b1111, 1, 4'b0100, 0);
        vec(0, 1, 4'b1111, 1, 4'b1000, 0);
        vec(0, 1, 4'b1111, 1, 4'b0001, 0);
        vec(0, 1, 4'b1111, 0, 4'b0001, 0);
        // owner 2 released with no other candidate, then Done while idle
        vec(0, 1, 4'b0100, 1, 4'b0100, 0);
        vec(0, 1, 4'b0100, 1, 4'b0000, 0);
        vec(0, 1, 4'b0000, 1, 4'b0000, 0);
        // En gating in IDLE, grant held in BUSY regardless of En
        for (int i = 0; i < 5; i++) vec(0, 0, 4'b0001, 0, 4'b0000, 0);
        vec(0, 1, 4'b0001, 0, 4'b0001, 0);
        vec(0, 0, 4'b0001, 0, 4'b0001, 0);
        vec(0, 0, 4'b1111, 0, 4'b0001, 0);
        vec(0, 0, 4'b0001, 1, 4'b0000, 0);
        // owner request drop acts as Done; former owner not re-granted on release
        vec(0, 1, 4'b0110, 0, 4'b0010, 0);
        vec(0, 1, 4'b0100, 0, 4'b0100, 0);
        vec(0, 1, 4'b0100, 1, 4'b0000, 0);
        vec(0, 1, 4'b0100, 0, 4'b0100, 0);
        // reset mid-grant, then index 0 favoured
        vec(0, 1, 4'b1100, 1, 4'b1000, 0);
        vec(1, 1, 4'b1001, 0, 4'b0000, 0);
        vec(0, 1, 4'b1001, 0, 4'b0001, 0);
        // reset beats Done/En/Req
        vec(1, 1, 4'b1111, 1, 4'b0000, 0);
        vec(0, 1, 4'b1111, 0, 4'b0001, 0);
        vec(0, 1, 4'b1111, 1, 4'b0010, 0);
        vec(0, 0, 4'b1111, 1, 4'b0000, 0);
`ifdef RR_TIMEOUT_EN
        // forced release after 4 held cycles with a one-cycle Timeout pulse
        vec(0, 1, 4'b0011, 0, 4'b0001, 0);
        vec(0, 1, 4'b0011, 0, 4'b0001, 0);
        vec(0, 1, 4'b0011, 0, 4'b0001, 0);
        vec(0, 1, 4'b0011, 0, 4'b0001, 0);
        vec(0, 1, 4'b0011, 0, 4'b0010, 1);
        vec(0, 1, 4'b0011, 0, 4'b0010, 0);
        vec(0, 1, 4'b0000, 1, 4'b0000, 0);
`else
        // grant held indefinitely, Timeout stays low
        vec(0, 1, 4'b0011, 0, 4'b0001, 0);
        for (int i = 0; i < 20; i++) vec(0, 1, 4'b0011, 0, 4'b0001, 0);
        vec(0, 1, 4'b0000, 1, 4'b0000, 0);
`endif

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge Clk);
        @(posedge Clk);
        if (exp_q.size() > 0) begin
            n_bad += exp_q.size();
            $display("FAIL drain: %0d expected results never checked, required 0", exp_q.size());
        end
        stim_done = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rr_arbiter4.md
RR_ARBITER4 -- requirements
Module: rr_arbiter4

Interface
REQ-001 Parameter: HOLD_MAX, 15, maximum consecutive grant cycles before forced release (used only with RR_TIMEOUT_EN; legal 1..255).
REQ-002 Port: Clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: Rst  input  1  reset, synchronous, active-high.
REQ-004 Port: En  input  1  arbitration enable; 0 blocks new grants only.
REQ-005 Port: Req  input  4  request vector; Req[i] from requester i.
REQ-006 Port: Done  input  1  current owner releases resource this cycle.
REQ-007 Port: Gnt  output  4  registered one-hot grant; all-zero when idle.
REQ-008 Port: GntIdx  output  2  binary index of Gnt bit; 2'b00 when Valid=0, never Z/X.
REQ-009 Port: Valid  output  1  high while any Gnt bit is set.
REQ-010 Port: Timeout  output  1  one-cycle pulse on forced release; present in both builds.

Function
REQ-011 FSM SHALL have two states: IDLE (no owner) and BUSY (one owner).
REQ-012 IDLE -> BUSY when En=1 and Req!=0; Gnt/GntIdx/Valid SHALL appear one cycle after Req is sampled.
REQ-013 Winner SHALL be the first set Req bit searching Ptr+1, Ptr+2, Ptr+3, Ptr (mod 4); Ptr is the last granted index.
REQ-014 Ptr SHALL update to the winner index in the same edge that sets Gnt.
REQ-015 In BUSY, Gnt SHALL hold unchanged regardless of other Req bits and En.
REQ-016 Release SHALL occur when Done=1, or when Req[owner]=0 (treated as Done).
REQ-017 On release, if En=1 and another arbitration candidate exists (Req with owner bit masked), next-cycle Gnt SHALL be the new winner (no idle gap); otherwise state -> IDLE and Gnt=0 next cycle.
REQ-018 Former owner SHALL NOT be re-granted on the release edge even if its Req stays high.
REQ-019 Done while IDLE SHALL be ignored.
REQ-020 Gnt SHALL be one-hot or zero every cycle; Valid SHALL equal |Gnt; GntIdx SHALL equal the encoded Gnt.
REQ-021 En=0 in IDLE SHALL keep Gnt=0 and Ptr unchanged.

Reset
REQ-022 Rst=1 at a clock edge SHALL force: state IDLE, Gnt=4'b0000, GntIdx=2'b00, Valid=0, Timeout=0, Ptr=3, hold counter 0.
REQ-023 Rst mid-grant SHALL drop the grant on that edge with no Timeout pulse; first post-reset grant favours index 0.
REQ-024 Rst SHALL take priority over all other inputs.

Configuration
REQ-025 Macro RR_TIMEOUT_EN defined: 8-bit hold counter counts BUSY cycles per owner, clears on every new grant; when owner has held Gnt HOLD_MAX cycles without release, grant SHALL be revoked as in REQ-017 and Timeout SHALL pulse high for that release edge's following cycle.
REQ-026 Macro RR_TIMEOUT_EN undefined: no counter instantiated, Timeout tied 0, grants held indefinitely.

Structure
REQ-027 Package arb_pkg SHALL hold NUM_REQ=4, IDX_W=2, the IDLE/BUSY state type, and the rotating-priority search function.
REQ-028 One sub-module, onehot_enc4, SHALL convert the 4-bit one-hot Gnt to GntIdx and output 2'b00 for zero input.
REQ-029 Target size 120-400 lines RTL including sub-module.

Verification
REQ-030 Reset then En=1, Req=4'b1010 -> after 1 cycle Gnt=4'b0010, GntIdx=2'b01, Valid=1.
REQ-031 Req=4'b1111 held, Done pulsed each grant -> grant order idx 0,1,2,3,0 with no idle cycles between grants.
REQ-032 Owner idx 2 with Req=4'b0100, Done=1 -> next cycle Gnt=0, Valid=0, GntIdx=2'b00; Done in IDLE -> no change.
REQ-033 En=0, Req=4'b0001 for 5 cycles -> Gnt=0 throughout; En->1 -> Gnt=4'b0001 next cycle; En->0 while BUSY -> grant held.
REQ-034 RR_TIMEOUT_EN, HOLD_MAX=4, Req=4'b0011, no Done -> Gnt=4'b0001 for 4 cycles, then Gnt=4'b0010 with Timeout=1 for one cycle.
REQ-035 Rst=1 while Gnt=4'b1000 -> next edge Gnt=0, Timeout=0; with Req=4'b1001 afterwards -> Gnt=4'b0001.
